// File: rtl/connect_four_pkg.sv
// Shared constants and types for the board frame scanner: cell encodings,
// default board geometry and the scanner state enum.
package connect_four_pkg;

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] PLAYER1 = 2'b01;
  localparam logic [1:0] PLAYER2 = 2'b10;

  localparam int DEF_ROWS     = 8;
  localparam int DEF_COLS     = 8;
  localparam int DEF_ROW_BITS = 3;
  localparam int DEF_COL_BITS = 3;

  typedef enum logic [1:0] {IDLE, HDR, SCAN, OUT} scan_state_e;

endpackage

// File: rtl/row_packer.sv
// Packs one board row: inserts each 2-bit cell at its column slot once the
// read latency has elapsed. Holds its word untouched while no insert arrives.
module row_packer
  import connect_four_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [2*COLS-1:0]     load_word_i,
  input  logic                  addr_vld_i,
  input  logic [COL_BITS-1:0]   addr_col_i,
  input  logic [1:0]            cell_i,
  output logic [2*COLS-1:0]     word_o
);

  logic                  ins_vld;
  logic [COL_BITS-1:0]   ins_col;
  logic [COLS-1:0][1:0]  cells_q, cells_d;

  // Column index travels alongside the board read so the cell lands in its slot.
  generate
    if (READ_LAT == 0) begin : g_nodly
      assign ins_vld = addr_vld_i;
      assign ins_col = addr_col_i;
    end else begin : g_dly
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ins_vld <= 1'b0;
          ins_col <= '0;
        end else begin
          ins_vld <= addr_vld_i;
          ins_col <= addr_col_i;
        end
      end
    end
  endgenerate

  always_comb begin
    cells_d = cells_q;
    if (clr_i) begin
      cells_d = '0;
    end else if (load_i) begin
      cells_d = load_word_i;
    end else if (ins_vld) begin
      for (int c = 0; c < COLS; c++) begin
        if (ins_col == COL_BITS'(c)) cells_d[c] = cell_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cells_q <= '0;
    else        cells_q <= cells_d;
  end

  assign word_o = cells_q;

endmodule

// File: rtl/board_frame_scanner.sv
// Sweeps the board top row first, packs each row into one word and streams it
// out over valid/ready. Define SCAN_CURSOR_EN to prefix each frame with a header word.
module board_frame_scanner
  import connect_four_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_req,
  output logic [ROW_BITS-1:0]  row_read,
  output logic [COL_BITS-1:0]  col_read,
  input  logic [1:0]           cell_in,
  input  logic                 game_over,
  input  logic [2:0]           cur_col,
  input  logic [1:0]           cur_player,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*COLS-1:0]    m_data,
  output logic [ROW_BITS-1:0]  m_row,
  output logic                 m_hdr,
  output logic                 m_last,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(COLS + READ_LAT + 1);
  localparam logic [CNT_W-1:0]    SCAN_END = CNT_W'(COLS + READ_LAT - 1);
  localparam logic [CNT_W-1:0]    CNT_COLS = CNT_W'(COLS);
  localparam logic [ROW_BITS-1:0] TOP_ROW  = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);

  scan_state_e          state_q, state_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic                 start, xfer, issue_vld, pk_clr, pk_load;
  logic [2*COLS-1:0]    hdr_word;

`ifdef SCAN_CURSOR_EN
  always_comb begin
    hdr_word      = '0;
    hdr_word[5:0] = {game_over, cur_player, cur_col};
  end
`else
  logic unused_hdr_in;
  assign unused_hdr_in = ^{game_over, cur_player, cur_col};
  assign hdr_word      = '0;
`endif

  assign xfer  = m_valid & m_ready;
  // A request landing on the frame_done cycle goes through pending, not straight in.
  assign start = (state_q == IDLE) & (pend_q | (frame_req & ~done_q));

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    issue_vld = 1'b0;
    pk_clr    = 1'b0;
    pk_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d  = TOP_ROW;
          col_d  = '0;
          cnt_d  = '0;
          pend_d = 1'b0;
`ifdef SCAN_CURSOR_EN
          state_d = HDR;
          pk_load = 1'b1;
`else
          state_d = SCAN;
          pk_clr  = 1'b1;
`endif
        end
      end
      HDR: begin
        if (xfer) begin
          state_d = SCAN;
          pk_clr  = 1'b1;
        end
      end
      SCAN: begin
        issue_vld = (cnt_q < CNT_COLS);
        if (col_q != LAST_COL) col_d = col_q + COL_BITS'(1);
        if (cnt_q == SCAN_END) state_d = OUT;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      OUT: begin
        if (xfer) begin
          col_d = '0;
          if (row_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SCAN;
            row_d   = row_q - ROW_BITS'(1);
            cnt_d   = '0;
            pk_clr  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_req && (state_q != IDLE || done_q) && !pend_d) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  row_packer #(
    .COLS     (COLS),
    .COL_BITS (COL_BITS),
    .READ_LAT (READ_LAT)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (pk_clr),
    .load_i      (pk_load),
    .load_word_i (hdr_word),
    .addr_vld_i  (issue_vld),
    .addr_col_i  (col_q),
    .cell_i      (cell_in),
    .word_o      (m_data)
  );

  assign row_read   = row_q;
  assign col_read   = col_q;
  assign m_valid    = (state_q == OUT) || (state_q == HDR);
  assign m_last     = (state_q == OUT) && (row_q == '0);
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
`ifdef SCAN_CURSOR_EN
  assign m_hdr = (state_q == HDR);
  assign m_row = (state_q == HDR) ? '0 : row_q;
`else
  assign m_hdr = 1'b0;
  assign m_row = row_q;
`endif

endmodule
